tlm_hvl2hdl_fifo: RTL

Buffers data from the HVL (Python) side into HDL logic, the opposite direction to the existing HDL-to-HVL FIFO. Testbench code calls the `put()` / `try_put()` tasks. The block presents entries to HDL logic through a valid/ready source interface on `clock`. Typical use is driving stimulus into a DUT from a pyhdl-if test.

---
 rtl/tlm_fifo_pkg.sv | 20 ++
 rtl/tlm_fifo_core.sv | 83 ++++++++
 rtl/tlm_hvl2hdl_fifo.sv | 117 +++++++++++
 3 files changed

// File: rtl/tlm_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlm_fifo_pkg
// Description : Pointer helpers shared by the HVL<->HDL TLM FIFOs.
// Revision    : 1.0  initial release
// ============================================================================
package tlm_fifo_pkg;

    // Pointer width able to index 'depth' entries (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Advance a circular-buffer pointer, wrapping from depth-1 to 0.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlm_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : tlm_fifo_core
// Description : Circular-buffer storage with read/write pointers, occupancy
//               count and push/pop arbitration. The head entry is held in a
//               register so the consumer never sees a path from pop_req.
// Revision    : 1.0  initial release
// ============================================================================
module tlm_fifo_core
    import tlm_fifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic             push_fire,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_next;
    logic [PW-1:0]    wr_next;
    logic             pop_fire;

    assign rd_next   = PW'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));
    assign wr_next   = PW'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
    assign valid     = (count != '0);
    assign pop_fire  = valid & pop_req;
    // A full buffer still accepts when the head leaves on the same edge.
    assign push_fire = reset & push_valid & ((count != CW'(DEPTH)) | pop_fire);

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clock) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_next;
            end
            if (pop_fire) begin
                rd_ptr <= rd_next;
            end
            if (push_fire && !pop_fire) begin
                count <= count + CW'(1);
            end else if (!push_fire && pop_fire) begin
                count <= count - CW'(1);
            end
            // Next head: following stored entry, or the entry arriving this
            // edge when it lands directly at the head; otherwise hold.
            if (pop_fire) begin
                if (count != CW'(1)) begin
                    head <= mem[rd_next];
                end else if (push_fire) begin
                    head <= push_data;
                end
            end else if (push_fire && (count == '0)) begin
                head <= push_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlm_hvl2hdl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tlm_hvl2hdl_fifo
// Description : HVL-to-HDL FIFO. HVL code calls put()/try_put(); entries are
//               presented to HDL logic through a valid/ready source port.
//               Optional macro TLM_HVL2HDL_FIFO_STATS_EN adds put/pop/peak
//               statistics counters and the get_stats() task.
// Revision    : 1.0  initial release
// ============================================================================
module tlm_hvl2hdl_fifo
    import tlm_fifo_pkg::*;
#(
    parameter int Tdepth = 4,
    parameter int Twidth = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic                           valid,
    input  logic                           ready,
    output logic [Twidth-1:0]              dat_o,
    output logic [$clog2(Tdepth+1)-1:0]    count
);

    localparam int CW = $clog2(Tdepth + 1);

    // Staging register: a put is staged while req_tgl differs from ack_tgl.
    bit [Twidth-1:0] stg_data;
    bit              req_tgl;
    bit              ack_tgl;
    logic            stg_valid;
    logic            push_fire;
    // Ticket pair serializing concurrent put() callers in arrival order.
    int unsigned     next_ticket;
    int unsigned     serving;

    assign stg_valid = req_tgl ^ ack_tgl;

    tlm_fifo_core #(
        .DEPTH (Tdepth),
        .WIDTH (Twidth)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .push_valid (stg_valid),
        .push_data  (stg_data),
        .pop_req    (ready),
        .push_fire  (push_fire),
        .valid      (valid),
        .count      (count),
        .head       (dat_o)
    );

    // Acknowledge a commit; not reset so a staged put survives reset.
    always_ff @(posedge clock) begin
        if (push_fire) begin
            ack_tgl <= ~ack_tgl;
        end
    end

    // Blocking put: wait for our turn, stage, return at the commit edge.
    task automatic put(input bit [Twidth-1:0] d);
        int unsigned my_ticket;
        my_ticket   = next_ticket;
        next_ticket = next_ticket + 1;
        wait (serving == my_ticket);
        stg_data = d;
        req_tgl  = ~req_tgl;
        wait (ack_tgl == req_tgl);
        serving = serving + 1;
    endtask

    // Non-blocking put: accepted only if nothing is staged or waiting and the
    // buffer can take an entry at the next edge given current state.
    task automatic try_put(input bit [Twidth-1:0] d, output int ok);
        if (!reset || stg_valid || (serving != next_ticket)) begin
            ok = 0;
        end else if ((count != CW'(Tdepth)) || (valid && ready)) begin
            put(d);
            ok = 1;
        end else begin
            ok = 0;
        end
    endtask

`ifdef TLM_HVL2HDL_FIFO_STATS_EN
    logic [31:0] n_put_cnt;
    logic [31:0] n_pop_cnt;
    logic [31:0] max_cnt;

    // Saturating commit/pop counters and peak occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_put_cnt <= '0;
            n_pop_cnt <= '0;
            max_cnt   <= '0;
        end else begin
            if (push_fire && (n_put_cnt != '1)) begin
                n_put_cnt <= n_put_cnt + 32'd1;
            end
            if (valid && ready && (n_pop_cnt != '1)) begin
                n_pop_cnt <= n_pop_cnt + 32'd1;
            end
            if (32'(count) > max_cnt) begin
                max_cnt <= 32'(count);
            end
        end
    end

    task automatic get_stats(output int n_put, output int n_pop, output int max_count);
        n_put     = int'(n_put_cnt);
        n_pop     = int'(n_pop_cnt);
        max_count = int'(max_cnt);
    endtask
`endif

endmodule
`default_nettype wire
